// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared state encodings, bus size codes and owner codes for
//                the fetch / MEM memory-bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter FSM states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } state_t;

    // Bus access size codes.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Owner of the transaction currently held in the request registers.
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one SRAM-like bus between instruction fetch and the
//                MEM stage. One transaction in flight, data has priority.
//                Flushed transactions still complete on the bus but their
//                result is dropped.
//  Ports       : clk, rst (sync, active-high), flush_i
//                inst_*   : fetch read request / response, streq_pc_o
//                data_*   : MEM load/store request / response, streq_mem_o
//                bus_*    : request/address/data handshake to the memory
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,

    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_valid_o,
    output logic              streq_pc_o,

    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_valid_o,
    output logic              streq_mem_o,

    output logic              bus_req_o,
    output logic              bus_wr_o,
    output logic [1:0]        bus_size_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_addr_ok_i,
    input  logic              bus_data_ok_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_size;
    logic                r_wr;
    logic                r_owner;
    logic                r_discard;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;
    logic                r_inst_valid;
    logic                r_data_valid;

    logic                w_data_go;
    logic                w_inst_go;

    // A requester still holds its request during its own valid cycle; it
    // must not be issued a second time then.
    assign w_data_go = data_req_i & ~r_data_valid;
    assign w_inst_go = inst_req_i & ~r_inst_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= 2'd0;
            r_wr         <= 1'b0;
            r_owner      <= OWNER_INST;
            r_discard    <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A flushing pipeline's requests are stale; issue nothing.
                    if (!flush_i) begin
                        if (w_data_go) begin
                            r_addr  <= data_addr_i;
                            r_wdata <= data_wdata_i;
                            r_size  <= data_size_i;
                            r_wr    <= data_wr_i;
                            r_owner <= OWNER_DATA;
                            r_state <= ST_D_ADDR;
                        end else if (w_inst_go) begin
                            r_addr  <= inst_addr_i;
                            r_wdata <= '0;
                            r_size  <= SIZE_W;
                            r_wr    <= 1'b0;
                            r_owner <= OWNER_INST;
                            r_state <= ST_I_ADDR;
                        end
                    end
                end
                ST_I_ADDR, ST_D_ADDR: begin
                    // The request cannot be withdrawn, so remember to drop it.
                    if (flush_i) begin
                        r_discard <= 1'b1;
                    end
                    if (bus_addr_ok_i) begin
                        if (r_state == ST_I_ADDR) begin
                            r_state <= ST_I_DATA;
                        end else begin
                            r_state <= ST_D_DATA;
                        end
                    end
                end
                ST_I_DATA, ST_D_DATA: begin
                    if (bus_data_ok_i) begin
                        r_discard <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (!(r_discard || flush_i)) begin
                            if (r_owner == OWNER_DATA) begin
                                r_data_rdata <= bus_rdata_i;
                                r_data_valid <= 1'b1;
                            end else begin
                                r_inst_rdata <= bus_rdata_i;
                                r_inst_valid <= 1'b1;
                            end
                        end
                    end else if (flush_i) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus fields come only from the latched request, so they stay stable
    // for the whole address phase regardless of requester activity.
    assign bus_req_o    = (r_state == ST_I_ADDR) || (r_state == ST_D_ADDR);
    assign bus_wr_o     = r_wr;
    assign bus_size_o   = r_size;
    assign bus_addr_o   = r_addr;
    assign bus_wdata_o  = r_wdata;

    assign inst_rdata_o = r_inst_rdata;
    assign inst_valid_o = r_inst_valid;
    assign data_rdata_o = r_data_rdata;
    assign data_valid_o = r_data_valid;

    assign streq_pc_o   = inst_req_i & ~r_inst_valid;
    assign streq_mem_o  = data_req_i & ~r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter: directed scenarios plus a
//                randomized phase with a bus slave model and a flush model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              inst_req_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic [DATA_W-1:0] inst_rdata_o;
    logic              inst_valid_o;
    logic              streq_pc_o;
    logic              data_req_i;
    logic              data_wr_i;
    logic [1:0]        data_size_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic [DATA_W-1:0] data_rdata_o;
    logic              data_valid_o;
    logic              streq_mem_o;
    logic              bus_req_o;
    logic              bus_wr_o;
    logic [1:0]        bus_size_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_addr_ok_i;
    logic              bus_data_ok_i;
    logic [DATA_W-1:0] bus_rdata_i;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .inst_req_i    (inst_req_i),
        .inst_addr_i   (inst_addr_i),
        .inst_rdata_o  (inst_rdata_o),
        .inst_valid_o  (inst_valid_o),
        .streq_pc_o    (streq_pc_o),
        .data_req_i    (data_req_i),
        .data_wr_i     (data_wr_i),
        .data_size_i   (data_size_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_rdata_o  (data_rdata_o),
        .data_valid_o  (data_valid_o),
        .streq_mem_o   (streq_mem_o),
        .bus_req_o     (bus_req_o),
        .bus_wr_o      (bus_wr_o),
        .bus_size_o    (bus_size_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_addr_ok_i (bus_addr_ok_i),
        .bus_data_ok_i (bus_data_ok_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_inst[$];
    txn_t        exp_data[$];
    txn_t        last_bus;
    txn_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          aw_force = 0;
    int          dw_force = 0;
    int          n_data_ok = 0;
    logic [31:0] last_inst_rdata = 32'h0;
    logic [31:0] last_data_rdata = 32'h0;

    // Memory content seen by the slave: a fixed function of the address.
    function automatic logic [31:0] fmem(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        return {a[15:0], ~a[31:16]} ^ 32'hC3C3_0F0F;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic req_inst(input logic [31:0] a);
        txn_t t;
        t.addr = a; t.wdata = 32'h0; t.size = 2'd2; t.wr = 1'b0; t.rdata = fmem(a);
        inst_req_i  = 1'b1;
        inst_addr_i = a;
        exp_inst.push_back(t);
    endtask

    task automatic req_data(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        txn_t t;
        t.addr = a; t.wdata = wd; t.size = sz; t.wr = wr; t.rdata = fmem(a);
        data_req_i   = 1'b1;
        data_wr_i    = wr;
        data_size_i  = sz;
        data_addr_i  = a;
        data_wdata_i = wd;
        exp_data.push_back(t);
    endtask

    // Called at a negedge; returns at the negedge of the valid cycle.
    task automatic wait_valid(input bit is_data, input int budget, output int lat);
        lat = 0;
        forever begin
            if (is_data ? data_valid_o : inst_valid_o) return;
            if (lat >= budget) begin
                check(is_data ? "data_valid_timeout" : "inst_valid_timeout", 128'd0, 128'd1);
                return;
            end
            tick();
            at_neg();
            lat++;
        end
    endtask

    // Bus slave: random or forced wait states, data_ok never with addr_ok.
    int   s_ph = 0;
    int   s_cnt = 0;
    logic s_bad = 1'b0;
    txn_t s_snap;
    initial begin
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        bus_rdata_i   = '0;
        forever begin
            @(negedge clk);
            bus_addr_ok_i = 1'b0;
            bus_data_ok_i = 1'b0;
            bus_rdata_i   = $urandom;
            if (rst) begin
                s_ph = 0;
                continue;
            end
            if (s_ph == 0 && bus_req_o) begin
                s_snap.addr = bus_addr_o; s_snap.wdata = bus_wdata_o;
                s_snap.size = bus_size_o; s_snap.wr    = bus_wr_o;
                s_bad = 1'b0;
                s_cnt = (aw_force >= 0) ? aw_force : $urandom_range(0, 3);
                s_ph  = 1;
            end
            if (s_ph == 1) begin
                if ({bus_req_o, bus_addr_o, bus_wdata_o, bus_size_o, bus_wr_o} !==
                    {1'b1, s_snap.addr, s_snap.wdata, s_snap.size, s_snap.wr})
                    s_bad = 1'b1;
                if (s_cnt == 0) begin
                    check("bus_fields_stable", {127'd0, s_bad}, 128'd0);
                    last_bus      = s_snap;
                    bus_addr_ok_i = 1'b1;
                    s_cnt = (dw_force >= 0) ? dw_force : $urandom_range(0, 3);
                    s_ph  = 2;
                end else begin
                    s_cnt--;
                end
            end else if (s_ph == 2) begin
                if (s_cnt == 0) begin
                    bus_data_ok_i = 1'b1;
                    bus_rdata_i   = fmem(last_bus.addr);
                    n_data_ok++;
                    s_ph = 0;
                end else begin
                    s_cnt--;
                end
            end
        end
    end

    // Monitor: pop and compare on every completion pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && inst_valid_o) begin
                if (exp_inst.size() == 0) begin
                    check("inst_unexpected_valid", 128'd1, 128'd0);
                end else begin
                    mon_e = exp_inst.pop_front();
                    check("inst_rdata", inst_rdata_o, mon_e.rdata);
                    check("inst_bus_txn", {last_bus.addr, last_bus.size, last_bus.wr},
                          {mon_e.addr, mon_e.size, mon_e.wr});
                    last_inst_rdata = mon_e.rdata;
                end
            end
            if (!rst && data_valid_o) begin
                if (exp_data.size() == 0) begin
                    check("data_unexpected_valid", 128'd1, 128'd0);
                end else begin
                    mon_e = exp_data.pop_front();
                    check("data_rdata", data_rdata_o, mon_e.rdata);
                    check("data_bus_txn", {last_bus.addr, last_bus.size, last_bus.wr},
                          {mon_e.addr, mon_e.size, mon_e.wr});
                    if (mon_e.wr) check("data_bus_wdata", last_bus.wdata, mon_e.wdata);
                    last_data_rdata = mon_e.rdata;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   lat;
    int   base;
    bit   ia, idrop, da, ddrop;
    logic [1:0] rsz;

    initial begin
        rst = 1'b1; flush_i = 1'b0;
        inst_req_i = 1'b0; inst_addr_i = '0;
        data_req_i = 1'b0; data_wr_i = 1'b0; data_size_i = 2'd0;
        data_addr_i = '0; data_wdata_i = '0;

        // Reset state
        tick(); tick(); tick();
        at_neg();
        check("reset_bus", {bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o}, 128'd0);
        check("reset_outputs", {inst_valid_o, data_valid_o, inst_rdata_o, data_rdata_o}, 128'd0);
        check("reset_streq_idle", {streq_pc_o, streq_mem_o}, 128'd0);
        tick(); inst_req_i = 1'b1; data_req_i = 1'b1;
        at_neg();
        check("reset_streq_req", {streq_pc_o, streq_mem_o}, 128'b11);
        tick(); inst_req_i = 1'b0; data_req_i = 1'b0; rst = 1'b0;
        at_neg();

        // Single instruction fetch, best-case timing
        aw_force = 0; dw_force = 0;
        tick(); req_inst(32'hBFC0_0000);
        at_neg();
        check("fetch_c0_streq", streq_pc_o, 128'd1);
        check("fetch_c0_bus_req", bus_req_o, 128'd0);
        tick(); at_neg();
        check("fetch_c1_bus", {bus_req_o, bus_addr_o, bus_size_o, bus_wr_o}, {1'b1, 32'hBFC0_0000, 2'd2, 1'b0});
        check("fetch_c1_streq", streq_pc_o, 128'd1);
        tick(); at_neg();
        check("fetch_c2_bus_req", bus_req_o, 128'd0);
        check("fetch_c2_state", {streq_pc_o, inst_valid_o}, 128'b10);
        tick(); at_neg();
        check("fetch_c3_valid", {inst_valid_o, streq_pc_o}, 128'b10);
        check("fetch_c3_rdata", inst_rdata_o, 32'h3C08_0001);
        tick(); inst_req_i = 1'b0;
        at_neg();
        check("fetch_valid_one_cycle", inst_valid_o, 128'd0);

        // Contention: data first, instruction issued from the data valid cycle
        tick(); req_inst(32'hBFC0_0010); req_data(1'b0, 2'd2, 32'h8000_0010, 32'h1234_5678);
        at_neg();
        tick(); at_neg();
        check("cont_first_issue", {bus_req_o, bus_wr_o, bus_addr_o}, {1'b1, 1'b0, 32'h8000_0010});
        tick(); at_neg();
        tick(); at_neg();
        check("cont_data_valid", {data_valid_o, bus_req_o}, 128'b10);
        tick(); data_req_i = 1'b0;
        at_neg();
        check("cont_inst_issue", {bus_req_o, bus_wr_o, bus_addr_o}, {1'b1, 1'b0, 32'hBFC0_0010});
        wait_valid(1'b0, 10, lat);
        check("cont_inst_latency", lat, 128'd2);
        tick(); inst_req_i = 1'b0;

        // Store with a slow address phase
        aw_force = 3; dw_force = 1;
        req_data(1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB);
        at_neg();
        tick(); at_neg();
        check("store_fields", {bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o},
              {1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB});
        wait_valid(1'b1, 20, lat);
        check("store_latency", lat, 128'd6);
        tick(); data_req_i = 1'b0; data_wr_i = 1'b0;

        // Flush during I_DATA
        aw_force = 0; dw_force = 2; base = n_data_ok;
        req_inst(32'hBFC0_0200);
        at_neg();
        tick(); at_neg();
        tick(); flush_i = 1'b1; exp_inst.delete();
        at_neg();
        tick(); flush_i = 1'b0; inst_req_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check("flush_idata_no_valid", inst_valid_o, 128'd0);
            check("flush_idata_rdata_kept", inst_rdata_o, last_inst_rdata);
            tick();
        end
        check("flush_idata_bus_completed", n_data_ok - base, 128'd1);
        aw_force = 0; dw_force = 0;
        req_inst(32'hBFC0_0380);
        at_neg();
        wait_valid(1'b0, 10, lat);
        check("refetch_latency", lat, 128'd3);
        tick(); inst_req_i = 1'b0;

        // Flush in the same cycle as data_ok
        aw_force = 0; dw_force = 1; base = n_data_ok;
        req_data(1'b0, 2'd1, 32'h8000_0042, 32'h0);
        at_neg();
        tick(); at_neg();
        tick(); at_neg();
        tick(); flush_i = 1'b1; exp_data.delete();
        at_neg();
        tick(); flush_i = 1'b0; data_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("flush_dok_no_valid", data_valid_o, 128'd0);
            check("flush_dok_rdata_kept", data_rdata_o, last_data_rdata);
            tick();
        end
        check("flush_dok_bus_completed", n_data_ok - base, 128'd1);
        aw_force = 0; dw_force = 0;
        req_data(1'b0, 2'd2, 32'h8000_0080, 32'h0);
        at_neg();
        wait_valid(1'b1, 10, lat);
        check("after_flush_load_latency", lat, 128'd3);
        tick(); data_req_i = 1'b0;

        // Reset while in D_ADDR
        aw_force = 5; dw_force = 0;
        req_data(1'b1, 2'd2, 32'h8000_0100, 32'hCAFE_F00D);
        at_neg();
        tick(); at_neg();
        check("rst_mid_pre_bus_req", bus_req_o, 128'd1);
        tick(); rst = 1'b1; data_req_i = 1'b0; exp_data.delete();
        at_neg();
        tick(); rst = 1'b0;
        at_neg();
        check("rst_mid_bus", {bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o}, 128'd0);
        check("rst_mid_valids", {inst_valid_o, data_valid_o}, 128'd0);

        // Randomized traffic with occasional flushes
        aw_force = -1; dw_force = -1;
        ia = 0; idrop = 0; da = 0; ddrop = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            flush_i = 1'b0;
            if (idrop) begin inst_req_i = 1'b0; ia = 0; idrop = 0; end
            if (ddrop) begin data_req_i = 1'b0; da = 0; ddrop = 0; end
            if ($urandom_range(0, 39) == 0) begin
                flush_i = 1'b1;
                if (ia) begin
                    if (!inst_valid_o) exp_inst.delete();
                    idrop = 1;
                end
                if (da) begin
                    if (!data_valid_o) exp_data.delete();
                    ddrop = 1;
                end
            end else begin
                if (!ia && $urandom_range(0, 2) == 0) begin
                    ia = 1;
                    req_inst(32'hBFC0_0000 | {14'd0, 16'($urandom), 2'b00});
                end
                if (!da && $urandom_range(0, 2) == 0) begin
                    da  = 1;
                    rsz = 2'($urandom_range(0, 2));
                    req_data(1'($urandom_range(0, 1)), rsz,
                             32'h8000_0000 | {16'd0, 16'($urandom)}, $urandom);
                end
                if (ia && inst_valid_o) idrop = 1;
                if (da && data_valid_o) ddrop = 1;
            end
        end

        // Drain outstanding requests
        flush_i = 1'b0;
        for (int c = 0; c < 300 && (ia || da); c++) begin
            tick();
            if (idrop) begin inst_req_i = 1'b0; ia = 0; idrop = 0; end
            if (ddrop) begin data_req_i = 1'b0; da = 0; ddrop = 0; end
            if (ia && inst_valid_o) idrop = 1;
            if (da && data_valid_o) ddrop = 1;
        end
        check("drain_done", {ia, da}, 128'd0);
        for (int c = 0; c < 20; c++) tick();
        check("queues_empty", exp_inst.size() + exp_data.size(), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
